// File: rtl/x_ramb_dp_asym.sv
// Dual-port RAM with independent port widths over one bit-addressed array.
// Optional macro X_RAMB_COLLISION_CHECK_EN marks same-edge write overlaps as X and flags COLLISION.
module x_ramb_dp_asym #(
   parameter int MEM_AW = 14,
   parameter int WIDTH_A = 1,
   parameter int WIDTH_B = 16,
   parameter logic [87:0] WRITE_MODE_A = "WRITE_FIRST",
   parameter logic [87:0] WRITE_MODE_B = "WRITE_FIRST",
   parameter int DO_REG_A = 0,
   parameter int DO_REG_B = 0,
   parameter logic [WIDTH_A-1:0] INIT_A = '0,
   parameter logic [WIDTH_B-1:0] INIT_B = '0,
   parameter logic [WIDTH_A-1:0] SRVAL_A = '0,
   parameter logic [WIDTH_B-1:0] SRVAL_B = '0,
   parameter logic [2**MEM_AW-1:0] INIT_MEM = '0,
   localparam int LA = $clog2(WIDTH_A),
   localparam int LB = $clog2(WIDTH_B),
   localparam int AW_A = MEM_AW - LA,
   localparam int AW_B = MEM_AW - LB
) (
   input  logic CLK,
   input  logic RST,
   input  logic ENA,
   input  logic WEA,
   input  logic SSRA,
   input  logic REGCEA,
   input  logic [AW_A-1:0] ADDRA,
   input  logic [WIDTH_A-1:0] DIA,
   output logic [WIDTH_A-1:0] DOA,
   input  logic ENB,
   input  logic WEB,
   input  logic SSRB,
   input  logic REGCEB,
   input  logic [AW_B-1:0] ADDRB,
   input  logic [WIDTH_B-1:0] DIB,
   output logic [WIDTH_B-1:0] DOB,
   output logic COLLISION
);

   localparam int MEM_BITS = 2**MEM_AW;
   localparam logic [87:0] WF = "WRITE_FIRST";
   localparam logic [87:0] RF = {8'h00, "READ_FIRST"};
   localparam logic [87:0] NC = {16'h0000, "NO_CHANGE"};

   function automatic bit legal_w(input int w);
      return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32);
   endfunction

   function automatic bit legal_m(input logic [87:0] m);
      return (m == WF) || (m == RF) || (m == NC);
   endfunction

   if (!legal_w(WIDTH_A) || !legal_w(WIDTH_B)) begin : g_bad_width
      $error("x_ramb_dp_asym: WIDTH_A/WIDTH_B must be 1, 2, 4, 8, 16 or 32");
   end
   if (!legal_m(WRITE_MODE_A) || !legal_m(WRITE_MODE_B)) begin : g_bad_mode
      $error("x_ramb_dp_asym: WRITE_MODE must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
   end
   if ((DO_REG_A != 0 && DO_REG_A != 1) || (DO_REG_B != 0 && DO_REG_B != 1)) begin : g_bad_doreg
      $error("x_ramb_dp_asym: DO_REG_A/DO_REG_B must be 0 or 1");
   end
   if (MEM_AW < LA || MEM_AW < LB || MEM_AW < 1) begin : g_bad_aw
      $error("x_ramb_dp_asym: MEM_AW too small for the port widths");
   end

   logic [MEM_BITS-1:0] mem_q = INIT_MEM;
   logic [MEM_AW-1:0]   bit_a, bit_b;
   logic                wr_a, wr_b;
   logic [WIDTH_A-1:0]  rd_a, lat_a_q, out_a_q;
   logic [WIDTH_B-1:0]  rd_b, lat_b_q, out_b_q;

   assign bit_a = MEM_AW'(ADDRA) << LA;
   assign bit_b = MEM_AW'(ADDRB) << LB;
   // Writes are gated combinationally so the array itself never sees the reset.
   assign wr_a  = ENA & WEA & ~RST;
   assign wr_b  = ENB & WEB & ~RST;
   assign rd_a  = mem_q[bit_a +: WIDTH_A];
   assign rd_b  = mem_q[bit_b +: WIDTH_B];

`ifdef X_RAMB_COLLISION_CHECK_EN
   localparam int LMAX = (LA > LB) ? LA : LB;
   localparam int WMIN = (WIDTH_A < WIDTH_B) ? WIDTH_A : WIDTH_B;
   logic              ovl;
   logic [MEM_AW-1:0] ovl_base;
   logic              coll_q;
   assign ovl      = (bit_a >> LMAX) == (bit_b >> LMAX);
   assign ovl_base = (LA <= LB) ? bit_a : bit_b;
   assign COLLISION = coll_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) coll_q <= 1'b0;
      else     coll_q <= wr_a & wr_b & ovl;
   end
`else
   assign COLLISION = 1'b0;
`endif

   // Port B is written last so its data wins wherever the two words overlap.
   always_ff @(posedge CLK) begin
      if (wr_a) mem_q[bit_a +: WIDTH_A] <= DIA;
      if (wr_b) mem_q[bit_b +: WIDTH_B] <= DIB;
`ifdef X_RAMB_COLLISION_CHECK_EN
      if (wr_a && wr_b && ovl) begin
         mem_q[ovl_base +: WMIN] <= 'x;
         $display("%0t x_ramb_dp_asym write collision ADDRA=%0d ADDRB=%0d", $time, ADDRA, ADDRB);
      end
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lat_a_q <= INIT_A;
      end else if (ENA) begin
         if (SSRA && DO_REG_A == 0)  lat_a_q <= SRVAL_A;
         else if (!WEA)              lat_a_q <= rd_a;
         else if (WRITE_MODE_A == WF) lat_a_q <= DIA;
         else if (WRITE_MODE_A == RF) lat_a_q <= rd_a;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lat_b_q <= INIT_B;
      end else if (ENB) begin
         if (SSRB && DO_REG_B == 0)  lat_b_q <= SRVAL_B;
         else if (!WEB)              lat_b_q <= rd_b;
         else if (WRITE_MODE_B == WF) lat_b_q <= DIB;
         else if (WRITE_MODE_B == RF) lat_b_q <= rd_b;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_a_q <= INIT_A;
         out_b_q <= INIT_B;
      end else begin
         if (REGCEA) out_a_q <= SSRA ? SRVAL_A : lat_a_q;
         if (REGCEB) out_b_q <= SSRB ? SRVAL_B : lat_b_q;
      end
   end

   assign DOA = (DO_REG_A != 0) ? out_a_q : lat_a_q;
   assign DOB = (DO_REG_B != 0) ? out_b_q : lat_b_q;

endmodule

// File: doc/x_ramb_dp_asym.md
X_RAMB_DP_ASYM -- requirements
Module: x_ramb_dp_asym

Interface
REQ-001 The block SHALL provide parameter MEM_AW, default 14, meaning log2 of total data bits (16384).
REQ-002 The block SHALL provide parameters WIDTH_A and WIDTH_B, default 1 and 16, meaning port data width, legal values 1/2/4/8/16/32.
REQ-003 The block SHALL provide parameters WRITE_MODE_A and WRITE_MODE_B, default "WRITE_FIRST", legal "WRITE_FIRST"/"READ_FIRST"/"NO_CHANGE".
REQ-004 The block SHALL provide parameters DO_REG_A and DO_REG_B, default 0, meaning 1 adds an output pipeline register.
REQ-005 The block SHALL provide parameters INIT_A/INIT_B (output reset value) and SRVAL_A/SRVAL_B (sync set/reset value), default 0, width WIDTH_x.
REQ-006 The block SHALL provide parameter INIT_MEM, default 0, width 2^MEM_AW, meaning initial memory contents, bit i = memory bit i.
REQ-007 The block SHALL derive AW_x = MEM_AW - log2(WIDTH_x) and stop elaboration with an error message on any illegal parameter value.
REQ-008 CLK  input  1  single clock, all ports sample on rising edge.
REQ-009 RST  input  1  reset, asynchronous, active-high.
REQ-010 ENA/ENB  input  1  port enable; WEA/WEB  input  1  write enable; SSRA/SSRB  input  1  sync set/reset of output.
REQ-011 REGCEA/REGCEB  input  1  output-register clock enable, ignored when DO_REG_x=0.
REQ-012 ADDRA  input  AW_A, DIA  input  WIDTH_A; ADDRB  input  AW_B, DIB  input  WIDTH_B.
REQ-013 DOA  output  WIDTH_A, DOB  output  WIDTH_B  read data; COLLISION  output  1  write-write overlap flag.

Function
REQ-014 Word at port address a SHALL occupy memory bits [a*WIDTH_x + WIDTH_x-1 : a*WIDTH_x], LSB at lowest bit index.
REQ-015 Write SHALL occur at rising CLK when EN=1 and WE=1, visible to either port's read on the next edge.
REQ-016 Latch stage, EN=1: SSR=1 -> SRVAL; else WE=0 -> mem word; WE=1 -> DI (WRITE_FIRST), old mem word (READ_FIRST), hold (NO_CHANGE); EN=0 -> hold.
REQ-017 With DO_REG_x=0 SSR SHALL apply at latch stage and DO SHALL equal latch stage, read latency 1 cycle.
REQ-018 With DO_REG_x=1 the latch stage SHALL ignore SSR, the output register SHALL load latch stage when REGCE=1, load SRVAL when REGCE=1 and SSR=1, hold when REGCE=0; read latency 2 cycles.
REQ-019 A port reading bits written by the other port in the same cycle SHALL return pre-write contents.
REQ-020 Address arithmetic SHALL not wrap; every legal address lies within memory (no out-of-range case).

Reset
REQ-021 RST=1 SHALL asynchronously set latch stage and output register of port A to INIT_A, of port B to INIT_B, and COLLISION to 0.
REQ-022 RST SHALL NOT alter memory contents; writes in a cycle where RST is high SHALL be suppressed.
REQ-023 After RST deasserts, the first rising CLK SHALL operate normally; reset mid-pipeline discards in-flight read data.

Configuration
REQ-024 Macro X_RAMB_COLLISION_CHECK_EN SHALL select collision handling.
REQ-025 Defined: simultaneous writes by both ports to overlapping bits SHALL store X in overlapping bits only, COLLISION SHALL pulse 1 the following cycle, and $display SHALL report time and both addresses.
REQ-026 Undefined: overlapping bits SHALL take port B data, COLLISION SHALL be constant 0, no message.

Verification
REQ-027 WIDTH_A=1, WIDTH_B=16: write DIB=16'hA5C3 at ADDRB=3, then read ADDRA=48..63 -> DOA sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
REQ-028 WIDTH_A=8, READ_FIRST, mem word 5 = 8'h11: write DIA=8'h22 at ADDRA=5 -> DOA=8'h11 next cycle; re-read -> 8'h22.
REQ-029 DO_REG_B=1, REGCEB=1: read ADDRB=0 holding 16'h1234 -> DOB=16'h1234 exactly 2 edges later; REGCEB=0 -> DOB holds.
REQ-030 SSRA=1, ENA=1, SRVAL_A=1 -> DOA=1 next edge regardless of WEA; ENA=0 -> no change.
REQ-031 With macro: port A writes bit 48 (ADDRA=48), port B writes ADDRB=3 same edge -> bit 48 reads X, other 15 bits port-B data, COLLISION=1 one cycle; without macro -> bit 48 = DIB[0], COLLISION=0.
REQ-032 Assert RST mid-read with DO_REG_A=1, INIT_A=1 -> DOA=1 immediately without clock edge; memory contents unchanged after release.
